// File: rtl/stream_fifo_level.sv
// Single-clock first-word-fall-through stream FIFO with registered fill level,
// programmable almost-full/almost-empty flags and synchronous flush.
module stream_fifo_level #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int AFULL_THR  = (2**AW) - 2,
  parameter int AEMPTY_THR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic [DW-1:0] stream_s_data_i,
  input  logic          stream_s_valid_i,
  output logic          stream_s_ready_o,
  output logic [DW-1:0] stream_m_data_o,
  output logic          stream_m_valid_o,
  input  logic          stream_m_ready_i,
  output logic [AW:0]   level_o,
  output logic          almost_full_o,
  output logic          almost_empty_o
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_THR);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_THR);

  if (AFULL_THR < 1 || AFULL_THR > DEPTH || AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1)
  begin : g_thr_check
    $error("stream_fifo_level: AFULL_THR/AEMPTY_THR out of range");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign stream_s_ready_o = !full && !flush_i;
  assign stream_m_valid_o = !empty;
  assign stream_m_data_o  = mem[rd_ptr[AW-1:0]];

  assign wr_en = stream_s_valid_i && stream_s_ready_o;
  assign rd_en = stream_m_valid_o && stream_m_ready_i && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= stream_s_data_i;
  end

  assign level_o        = level;
  assign almost_full_o  = (level >= AFULL_LVL);
  assign almost_empty_o = (level <= AEMPTY_LVL);

endmodule

// File: tb/tb_stream_fifo_level.sv
// Bench for stream_fifo_level: constant vector table, corner-case sequences and a
// randomized soak, all checked against a queue-based reference model.
module tb_stream_fifo_level;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  level;
  logic        afull;
  logic        aempty;

  stream_fifo_level #(.DW(16), .AW(4), .AFULL_THR(14), .AEMPTY_THR(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .stream_s_data_i(s_data), .stream_s_valid_i(s_valid), .stream_s_ready_o(s_ready),
    .stream_m_data_o(m_data), .stream_m_valid_o(m_valid), .stream_m_ready_i(m_ready),
    .level_o(level), .almost_full_o(afull), .almost_empty_o(aempty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [15:0] q[$];
  bit          mchk = 0;
  bit          wr_acc, rd_acc;
  logic        smp_rdy, smp_vld, smp_af, smp_ae;
  logic [15:0] smp_data;
  logic [4:0]  smp_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, sample/compare at negedge, advance the model at posedge.
  task automatic cycle(input logic r, input logic fl, input logic v, input logic [15:0] d,
                       input logic rd);
    int sz;
    rst = r; flush_i = fl; s_valid = v; s_data = d; m_ready = rd;
    @(negedge clk);
    smp_rdy = s_ready; smp_vld = m_valid; smp_data = m_data;
    smp_lvl = level; smp_af = afull; smp_ae = aempty;
    sz = q.size();
    if (mchk) begin
      chk("model_ready", 32'(s_ready), 32'((sz < 16) && !fl));
      chk("model_valid", 32'(m_valid), 32'(sz > 0));
      chk("model_level", 32'(level), 32'(sz));
      chk("model_afull", 32'(afull), 32'(sz >= 14));
      chk("model_aempty", 32'(aempty), 32'(sz <= 1));
      if (sz > 0) chk("model_data", 32'(m_data), 32'(q[0]));
    end
    wr_acc = !r && v && (sz < 16) && !fl;
    rd_acc = !r && rd && (sz > 0) && !fl;
    @(posedge clk);
    if (r) begin
      q.delete(); mchk = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (rd_acc) void'(q.pop_front());
      if (wr_acc) q.push_back(d);
    end
    #1;
  endtask

  typedef struct {
    logic        r, fl, v;
    logic [15:0] d;
    logic        rd;
    logic        e_rdy, e_vld;
    logic [15:0] e_data;
    logic [4:0]  e_lvl;
    logic        e_af, e_ae;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc, wrate, rrate;
    logic        wv, rr;
    logic [15:0] wd;

    //          rst fl v  data     rd  rdy vld data     lvl af ae
    tbl[0]  = '{1, 0, 1, 16'hAAAA, 0,  1,  0, 16'h0000, 0,  0, 1};
    tbl[1]  = '{1, 0, 1, 16'hAAAA, 0,  1,  0, 16'h0000, 0,  0, 1};
    tbl[2]  = '{0, 0, 1, 16'h1111, 0,  1,  0, 16'h0000, 0,  0, 1};
    tbl[3]  = '{0, 0, 1, 16'h2222, 0,  1,  1, 16'h1111, 1,  0, 1};
    tbl[4]  = '{0, 0, 1, 16'h3333, 1,  1,  1, 16'h1111, 2,  0, 0};
    tbl[5]  = '{0, 0, 0, 16'h0000, 0,  1,  1, 16'h2222, 2,  0, 0};
    tbl[6]  = '{0, 1, 1, 16'hBEEF, 1,  0,  1, 16'h2222, 2,  0, 0};
    tbl[7]  = '{0, 0, 1, 16'hBEEF, 0,  1,  0, 16'h0000, 0,  0, 1};
    tbl[8]  = '{0, 0, 0, 16'h0000, 1,  1,  1, 16'hBEEF, 1,  0, 1};
    tbl[9]  = '{1, 1, 1, 16'h5555, 0,  0,  0, 16'h0000, 0,  0, 1};
    tbl[10] = '{0, 0, 0, 16'h0000, 0,  1,  0, 16'h0000, 0,  0, 1};

    @(posedge clk); #1;
    cycle(1, 0, 1, 16'hAAAA, 0);

    // Reset, basic write/read, simultaneous read+write, flush, rst over flush
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d_ready", i), 32'(smp_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(smp_vld), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_level", i), 32'(smp_lvl), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_afull", i), 32'(smp_af), 32'(tbl[i].e_af));
      chk($sformatf("vec%0d_aempty", i), 32'(smp_ae), 32'(tbl[i].e_ae));
      if (tbl[i].e_vld) chk($sformatf("vec%0d_data", i), 32'(smp_data), 32'(tbl[i].e_data));
    end

    // Fill to capacity
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, 1, 16'(i), 0);
      if (i == 13) chk("fill_afull_13", 32'(afull), 32'd0);
      if (i == 14) chk("fill_afull_14", 32'(afull), 32'd1);
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(s_ready), 32'd0);
    cycle(0, 0, 1, 16'h0011, 0);
    chk("full_refuse_level", 32'(level), 32'd16);

    // Read while full does not admit the held write in the same cycle
    cycle(0, 0, 1, 16'h0011, 1);
    chk("fullrd_ready_before", 32'(smp_rdy), 32'd0);
    chk("fullrd_head", 32'(smp_data), 32'h0001);
    chk("fullrd_level", 32'(level), 32'd15);
    chk("fullrd_ready_after", 32'(s_ready), 32'd1);
    cycle(0, 0, 1, 16'h0011, 0);
    chk("refill_level", 32'(level), 32'd16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(m_data), 32'(i + 2));
      cycle(0, 0, 0, 16'h0000, 1);
      if (i == 13) chk("drain_aempty_l2", 32'(aempty), 32'd0);
      if (i == 14) chk("drain_aempty_l1", 32'(aempty), 32'd1);
    end
    chk("drained_valid", 32'(m_valid), 32'd0);
    chk("drained_level", 32'(level), 32'd0);

    // Flush at level 5 with a concurrent write
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 16'(16'h0A00 + i), 0);
    chk("preflush_level", 32'(level), 32'd5);
    cycle(0, 1, 1, 16'hBEEF, 0);
    chk("flush_ready", 32'(smp_rdy), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(m_valid), 32'd0);
    cycle(0, 0, 1, 16'hBEEF, 0);
    chk("postflush_head", 32'(m_data), 32'hBEEF);
    chk("postflush_valid", 32'(m_valid), 32'd1);
    cycle(0, 0, 0, 16'h0000, 1);

    // Randomized soak, two rate profiles (write%, read%)
    for (int ph = 0; ph < 2; ph++) begin
      wrate = (ph == 0) ? 30 : 90;
      rrate = (ph == 0) ? 90 : 30;
      sent = 0; cyc = 0; wv = 0; wd = '0;
      while (sent < 2400 && cyc < 30000) begin
        if (!wv && $urandom_range(99) < wrate) begin
          wv = 1; wd = 16'($urandom);
        end
        rr = ($urandom_range(99) < rrate);
        cycle(0, 0, wv, wd, rr);
        if (wr_acc) begin wv = 0; sent++; end
        cyc++;
      end
      chk("soak_words_sent", 32'(sent), 32'd2400);
      cyc = 0;
      while (q.size() > 0 && cyc < 100) begin
        cycle(0, 0, 0, 16'h0000, 1);
        cyc++;
      end
      chk("soak_drain_level", 32'(level), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
